iobus_periph_hub: RTL and testbench
===================================

# iobus_periph_hub

Parametrised memory-mapped peripheral hub on the OTTER IOBUS, replacing the fixed switch/LED/seven-segment/cycle-counter decode logic in the board wrapper. It provides:
- a configurable-width synchronised input port with sticky rising-edge flags and a maskable interrupt;
- a configurable-width LED output register and a 16-bit seven-segment data register;
- a prescaled free-running cycle counter whose high word is snapshotted atomically on every low-word read.

It sits between `otter_mcu` and the board I/O, clocked by the MCU clock.

## Interface
Parameters:
- `IN_W`, 16: width of input port (1–32).
- `OUT_W`, 16: width of LED register (1–32).
- `CNT_W`, 64: counter width (33–64).
- `PRESCALE`, 1: counter increments once every `PRESCALE` enabled cycles (1–65535).
- `IN_AD`, 32'h11000000: synced input read address.
- `EDGE_AD`, 32'h11000004: edge flags, read / write-1-to-clear.
- `MASK_AD`, 32'h11000008: interrupt mask, read/write.
- `LEDS_AD`, 32'h1107ffff: LED register, read/write.
- `SSEG_AD`, 32'h110C0000: seven-segment register, read/write.
- `CNTLO_AD`, 32'h11400000: counter low word.
- `CNTHI_AD`, 32'h11400004: snapshotted counter high word.
- `CNTCTL_AD`, 32'h11400008: counter control.

Ports:
- `CLK` in 1: MCU clock; one clock for the whole block.
- `RESET` in 1: asynchronous, active-high reset.
- `IOBUS_ADDR` in 32: bus address.
- `IOBUS_OUT` in 32: write data from MCU.
- `IOBUS_WR` in 1: write strobe, one cycle per store.
- `IOBUS_RD` in 1: read strobe, one cycle per load.
- `IOBUS_IN` out 32: read data to MCU.
- `SWITCHES` in `IN_W`: asynchronous board inputs.
- `LEDS` out `OUT_W`: LED register.
- `SSEG` out 16: seven-segment data.
- `INTR` out 1: registered interrupt request, level.

## Operation
- Reset values:
  - `LEDS`, `SSEG`, EDGE, MASK, sync flops, counter, prescaler, high-word snapshot, and `INTR` are all 0.
  - Control bit0 (EN) is 1.
- Input port:
  - Two-flop synchroniser per bit, followed by a third "previous" flop.
  - EDGE[i] sets when synced[i]=1 and prev[i]=0.
  - A write to `EDGE_AD` clears each bit whose `IOBUS_OUT` bit is 1.
  - If a set and a clear hit the same bit in the same cycle, set wins.
- Interrupt: `INTR` <= |(EDGE & MASK), registered.
- Registers `LEDS`, `SSEG`, and MASK load `IOBUS_OUT` (low bits) on `IOBUS_WR` with a matching address.
- Counter:
  - While EN=1, the prescaler counts 0..`PRESCALE`-1.
  - On terminal count, the prescaler returns to 0 and the counter increments, wrapping at 2^`CNT_W` to 0.
- Control write to `CNTCTL_AD`:
  - bit0 → EN.
  - bit1=1 zeroes counter and prescaler at that edge. bit1 is self-clearing and reads 0.
  - Clear has priority over increment in the same cycle.
  - While EN=0, counter and prescaler hold.
- Atomic counter read:
  - An `IOBUS_RD` at `CNTLO_AD` returns the live low 32 bits.
  - In the same edge, counter bits [`CNT_W`-1:32] are latched into the snapshot.
  - `CNTHI_AD` returns the snapshot, zero-extended, never the live value.
- Read mux: `IOBUS_IN` is combinational from `IOBUS_ADDR`.
  - Returns register contents zero-extended to 32 bits.
  - Returns 0 for unmapped addresses.
  - Writes to read-only addresses (`IN_AD`, `CNTLO_AD`, `CNTHI_AD`) are ignored.
- Simultaneous `IOBUS_WR` and `IOBUS_RD` in one cycle: both take effect.
- Reset asserted mid-operation clears all state immediately, independent of `CLK`. Flags pending at reset are lost.

## Timing
- Read data is valid in the same cycle as the address, since the mux is combinational.
- Writes take effect at the rising edge where `IOBUS_WR`=1. Readback reflects the new value in the next cycle.
- `SWITCHES` change → IN readback: 2 edges.
- `SWITCHES` change → EDGE set: 3 edges.
- `SWITCHES` change → `INTR`: 4 edges.
- W1C clear of the last masked flag: `INTR` falls 1 edge later.
- With `PRESCALE`=1, the counter advances every cycle. Otherwise it advances on every `PRESCALE`th enabled cycle.
- Snapshot is taken at the `CNTLO_AD` read edge. A `CNTHI_AD` read on any later cycle returns the high word consistent with that low word.

## Test plan
- Reset → counter: assert `RESET` mid-count. All outputs go to 0 asynchronously and EN reads 1. Release; after 10 cycles, `CNTLO_AD` reads 10.
- Edge/INTR:
  - MASK=0x0004, raise `SWITCHES`[2] → EDGE reads 0x0004 after 3 edges and `INTR`=1 after 4.
  - Write 0x0004 to `EDGE_AD` → `INTR`=0 next cycle.
  - Repeat with a set and clear in the same cycle → bit remains 1.
- Counter wrap/snapshot:
  - Preload by running with `CNT_W`=33 to 0x0_FFFFFFFF, then read LO → 0xFFFFFFFF.
  - Next-cycle HI → 0, even though the live value has wrapped to 0x1_00000000.
  - Read LO again, then HI → 1.
- Prescale/control:
  - `PRESCALE`=4: 20 cycles → LO=5.
  - Write EN=0 → value frozen for 50 cycles.
  - Write 0x3 → next LO read is 0 (plus elapsed increments).
- Output registers:
  - Write 0xBEEF to `LEDS_AD` and 0x1234 to `SSEG_AD` → `LEDS`=0xBEEF, `SSEG`=0x1234, and both read back.
  - Write to `IN_AD` → no change.
  - Read 0x11000010 → 0.

Source files
------------

// File: rtl/iobus_periph_hub.sv
// OTTER IOBUS peripheral hub: synchronised inputs with sticky edge flags and
// maskable interrupt, LED/seven-segment registers, prescaled cycle counter.
module iobus_periph_hub #(
  parameter int unsigned IN_W      = 16,
  parameter int unsigned OUT_W     = 16,
  parameter int unsigned CNT_W     = 64,
  parameter int unsigned PRESCALE  = 1,
  parameter logic [31:0] IN_AD     = 32'h11000000,
  parameter logic [31:0] EDGE_AD   = 32'h11000004,
  parameter logic [31:0] MASK_AD   = 32'h11000008,
  parameter logic [31:0] LEDS_AD   = 32'h1107ffff,
  parameter logic [31:0] SSEG_AD   = 32'h110C0000,
  parameter logic [31:0] CNTLO_AD  = 32'h11400000,
  parameter logic [31:0] CNTHI_AD  = 32'h11400004,
  parameter logic [31:0] CNTCTL_AD = 32'h11400008,
  // Counter value loaded by reset; nonzero only to start bring-up near a wrap.
  parameter logic [CNT_W-1:0] CNT_RST = '0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [31:0]       IOBUS_ADDR,
  input  logic [31:0]       IOBUS_OUT,
  input  logic              IOBUS_WR,
  input  logic              IOBUS_RD,
  output logic [31:0]       IOBUS_IN,
  input  logic [IN_W-1:0]   SWITCHES,
  output logic [OUT_W-1:0]  LEDS,
  output logic [15:0]       SSEG,
  output logic              INTR
);

  localparam logic [15:0]      PRESC_TC = 16'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [IN_W-1:0]   sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [IN_W-1:0]   edge_q, edge_d, mask_q, mask_d;
  logic [OUT_W-1:0]  leds_q, leds_d;
  logic [15:0]       sseg_q, sseg_d;
  logic              intr_q, intr_d;
  logic              en_q, en_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       presc_q, presc_d;
  logic [CNT_W-33:0] snap_q, snap_d;

  logic wr_edge, wr_mask, wr_leds, wr_sseg, wr_ctl, rd_lo;
  logic unused_bits;

  assign unused_bits = ^IOBUS_OUT;

  always_comb begin
    wr_edge = IOBUS_WR && (IOBUS_ADDR == EDGE_AD);
    wr_mask = IOBUS_WR && (IOBUS_ADDR == MASK_AD);
    wr_leds = IOBUS_WR && (IOBUS_ADDR == LEDS_AD);
    wr_sseg = IOBUS_WR && (IOBUS_ADDR == SSEG_AD);
    wr_ctl  = IOBUS_WR && (IOBUS_ADDR == CNTCTL_AD);
    rd_lo   = IOBUS_RD && (IOBUS_ADDR == CNTLO_AD);
  end

  always_comb begin
    sync1_d = SWITCHES;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    // Clear first, then OR in new edges so a coincident set survives.
    edge_d  = edge_q;
    if (wr_edge) edge_d = edge_d & ~IOBUS_OUT[IN_W-1:0];
    edge_d  = edge_d | (sync2_q & ~prev_q);
    mask_d  = wr_mask ? IOBUS_OUT[IN_W-1:0]  : mask_q;
    leds_d  = wr_leds ? IOBUS_OUT[OUT_W-1:0] : leds_q;
    sseg_d  = wr_sseg ? IOBUS_OUT[15:0]      : sseg_q;
    intr_d  = |(edge_q & mask_q);
    en_d    = wr_ctl ? IOBUS_OUT[0] : en_q;
    cnt_d   = cnt_q;
    presc_d = presc_q;
    if (wr_ctl && IOBUS_OUT[1]) begin
      cnt_d   = '0;
      presc_d = '0;
    end else if (en_q) begin
      if (presc_q == PRESC_TC) begin
        presc_d = '0;
        cnt_d   = cnt_q + CNT_ONE;
      end else begin
        presc_d = presc_q + 16'd1;
      end
    end
    snap_d  = rd_lo ? cnt_q[CNT_W-1:32] : snap_q;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      edge_q  <= '0;
      mask_q  <= '0;
      leds_q  <= '0;
      sseg_q  <= '0;
      intr_q  <= 1'b0;
      en_q    <= 1'b1;
      cnt_q   <= CNT_RST;
      presc_q <= '0;
      snap_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      edge_q  <= edge_d;
      mask_q  <= mask_d;
      leds_q  <= leds_d;
      sseg_q  <= sseg_d;
      intr_q  <= intr_d;
      en_q    <= en_d;
      cnt_q   <= cnt_d;
      presc_q <= presc_d;
      snap_q  <= snap_d;
    end
  end

  always_comb begin
    IOBUS_IN = '0;
    case (IOBUS_ADDR)
      IN_AD:     IOBUS_IN = 32'(sync2_q);
      EDGE_AD:   IOBUS_IN = 32'(edge_q);
      MASK_AD:   IOBUS_IN = 32'(mask_q);
      LEDS_AD:   IOBUS_IN = 32'(leds_q);
      SSEG_AD:   IOBUS_IN = 32'(sseg_q);
      CNTLO_AD:  IOBUS_IN = cnt_q[31:0];
      CNTHI_AD:  IOBUS_IN = 32'(snap_q);
      CNTCTL_AD: IOBUS_IN = {31'd0, en_q};
      default:   IOBUS_IN = '0;
    endcase
  end

  assign LEDS = leds_q;
  assign SSEG = sseg_q;
  assign INTR = intr_q;

endmodule

// File: tb/tb_iobus_periph_hub.sv
// Directed bench for iobus_periph_hub: default, prescaled and 33-bit counter
// instances share one bus; expectations flow through a scoreboard queue.
module tb_iobus_periph_hub;

  localparam logic [31:0] IN_AD     = 32'h11000000;
  localparam logic [31:0] EDGE_AD   = 32'h11000004;
  localparam logic [31:0] MASK_AD   = 32'h11000008;
  localparam logic [31:0] LEDS_AD   = 32'h1107ffff;
  localparam logic [31:0] SSEG_AD   = 32'h110C0000;
  localparam logic [31:0] CNTLO_AD  = 32'h11400000;
  localparam logic [31:0] CNTHI_AD  = 32'h11400004;
  localparam logic [31:0] CNTCTL_AD = 32'h11400008;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wdata;
  logic        wr, rd;
  logic [15:0] sw;
  logic [31:0] in0, in4, inw;
  logic [15:0] leds0, leds4, ledsw, sseg0, sseg4, ssegw;
  logic        intr0, intr4, intrw;

  always #5 clk = ~clk;

  iobus_periph_hub dut0 (
    .CLK(clk), .RESET(rst), .IOBUS_ADDR(addr), .IOBUS_OUT(wdata),
    .IOBUS_WR(wr), .IOBUS_RD(rd), .IOBUS_IN(in0), .SWITCHES(sw),
    .LEDS(leds0), .SSEG(sseg0), .INTR(intr0)
  );

  iobus_periph_hub #(.PRESCALE(4)) dut4 (
    .CLK(clk), .RESET(rst), .IOBUS_ADDR(addr), .IOBUS_OUT(wdata),
    .IOBUS_WR(wr), .IOBUS_RD(rd), .IOBUS_IN(in4), .SWITCHES(sw),
    .LEDS(leds4), .SSEG(sseg4), .INTR(intr4)
  );

  iobus_periph_hub #(.CNT_W(33), .CNT_RST(33'h0_FFFF_FFF0)) dutw (
    .CLK(clk), .RESET(rst), .IOBUS_ADDR(addr), .IOBUS_OUT(wdata),
    .IOBUS_WR(wr), .IOBUS_RD(rd), .IOBUS_IN(inw), .SWITCHES(sw),
    .LEDS(ledsw), .SSEG(ssegw), .INTR(intrw)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  function automatic logic [31:0] bus_in(input int sel);
    case (sel)
      0:       return in0;
      1:       return in4;
      default: return inw;
    endcase
  endfunction

  task automatic push(input string tag, input logic [31:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    logic [31:0] e;
    string t;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_underflow: observed 0x%08h required an expectation", obs);
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", t, obs, e);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd_peek(input int sel, input logic [31:0] a, input logic [31:0] e,
                         input string tag);
    addr = a;
    rd   = 1'b0;
    push(tag, e);
    #1;
    pop_check(bus_in(sel));
  endtask

  task automatic rd_strobe(input int sel, input logic [31:0] a, input logic [31:0] e,
                           input string tag);
    addr = a;
    rd   = 1'b1;
    push(tag, e);
    #1;
    pop_check(bus_in(sel));
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic chk(input string tag, input int which, input logic [31:0] e);
    push(tag, e);
    #1;
    case (which)
      0:       pop_check(32'(leds0));
      1:       pop_check(32'(sseg0));
      default: pop_check({31'd0, intr0});
    endcase
  endtask

  task automatic wr_bus(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wr    = 1'b1;
    @(negedge clk);
    wr    = 1'b0;
    wdata = '0;
  endtask

  initial begin
    rst = 1'b1; addr = '0; wdata = '0; wr = 1'b0; rd = 1'b0; sw = '0;

    // Reset state, then free counting from release
    chk("rst_leds", 0, 32'h0);
    chk("rst_sseg", 1, 32'h0);
    chk("rst_intr", 2, 32'h0);
    rd_peek(0, CNTCTL_AD, 32'h1, "rst_ctl_en");
    step(1);
    rst = 1'b0;
    step(10);
    rd_peek(0, CNTLO_AD, 32'd10, "cnt_10_after_reset");

    // Output registers and read-only / unmapped addresses
    wr_bus(LEDS_AD, 32'h1234_BEEF);
    wr_bus(SSEG_AD, 32'hABCD_1234);
    chk("leds_out", 0, 32'hBEEF);
    chk("sseg_out", 1, 32'h1234);
    rd_peek(0, LEDS_AD, 32'hBEEF, "leds_rb");
    rd_peek(0, SSEG_AD, 32'h1234, "sseg_rb");
    wr_bus(IN_AD, 32'hFFFF_FFFF);
    rd_peek(0, IN_AD, 32'h0, "in_ro");
    chk("leds_after_in_wr", 0, 32'hBEEF);
    rd_peek(0, 32'h11000010, 32'h0, "unmapped");

    // Edge flags and interrupt latency
    wr_bus(MASK_AD, 32'h4);
    rd_peek(0, MASK_AD, 32'h4, "mask_rb");
    sw = 16'h0004;
    step(1);
    rd_peek(0, IN_AD, 32'h0, "in_1edge");
    step(1);
    rd_peek(0, IN_AD, 32'h4, "in_2edge");
    rd_peek(0, EDGE_AD, 32'h0, "edge_2edge");
    step(1);
    rd_peek(0, EDGE_AD, 32'h4, "edge_3edge");
    chk("intr_3edge", 2, 32'h0);
    step(1);
    chk("intr_4edge", 2, 32'h1);
    wr_bus(EDGE_AD, 32'h4);
    rd_peek(0, EDGE_AD, 32'h0, "edge_w1c");
    chk("intr_w1c_lag", 2, 32'h1);
    step(1);
    chk("intr_fall", 2, 32'h0);
    sw = 16'h0005;
    step(3);
    rd_peek(0, EDGE_AD, 32'h1, "edge_unmasked");
    step(1);
    chk("intr_unmasked", 2, 32'h0);
    sw = 16'h0001;
    step(3);
    wr_bus(EDGE_AD, 32'h1);
    sw = 16'h0005;
    step(2);
    wr_bus(EDGE_AD, 32'h4);
    rd_peek(0, EDGE_AD, 32'h4, "edge_set_wins");
    step(1);
    chk("intr_after_collision", 2, 32'h1);

    // Asynchronous reset with a pending flag and EN cleared
    wr_bus(CNTCTL_AD, 32'h0);
    step(1);
    rst = 1'b1;
    chk("mid_rst_intr", 2, 32'h0);
    chk("mid_rst_leds", 0, 32'h0);
    chk("mid_rst_sseg", 1, 32'h0);
    step(1);
    rd_peek(0, EDGE_AD, 32'h0, "mid_rst_edge");
    rd_peek(0, CNTLO_AD, 32'h0, "mid_rst_cnt");
    rd_peek(0, CNTCTL_AD, 32'h1, "mid_rst_en");
    sw = '0;
    step(1);
    rst = 1'b0;

    // Prescaler and counter control
    step(20);
    rd_peek(1, CNTLO_AD, 32'd5, "p4_20cyc");
    rd_peek(0, CNTLO_AD, 32'd20, "p1_20cyc");
    wr_bus(CNTCTL_AD, 32'h0);
    step(50);
    rd_peek(1, CNTLO_AD, 32'd5, "p4_frozen");
    rd_peek(0, CNTLO_AD, 32'd21, "p1_frozen");
    rd_peek(0, CNTCTL_AD, 32'h0, "ctl_en0");
    wr_bus(CNTCTL_AD, 32'h3);
    rd_peek(1, CNTLO_AD, 32'd0, "p4_cleared");
    rd_peek(0, CNTLO_AD, 32'd0, "p1_cleared");
    rd_peek(0, CNTCTL_AD, 32'h1, "ctl_clr_selfclear");
    step(4);
    rd_peek(1, CNTLO_AD, 32'd1, "p4_after4");
    rd_peek(0, CNTLO_AD, 32'd4, "p1_after4");
    wr_bus(CNTCTL_AD, 32'h3);
    rd_peek(0, CNTLO_AD, 32'd0, "clr_over_inc");

    // Snapshot across the 32-bit boundary on the 33-bit counter
    step(1);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    step(15);
    rd_peek(2, CNTHI_AD, 32'h0, "w_hi_reset");
    rd_strobe(2, CNTLO_AD, 32'hFFFF_FFFF, "w_lo_pre_wrap");
    rd_peek(2, CNTHI_AD, 32'h0, "w_hi_snap0");
    rd_peek(2, CNTLO_AD, 32'h0, "w_lo_live_wrapped");
    rd_strobe(2, CNTLO_AD, 32'h0, "w_lo_again");
    rd_peek(2, CNTHI_AD, 32'h1, "w_hi_snap1");
    step(3);
    rd_peek(2, CNTHI_AD, 32'h1, "w_hi_stable");

    n_tests++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d pending expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
